// File: rtl/logical_tile_io_array_cfg.sv
// Multi-channel embedded IO tile with a counted configuration chain.
// Optional chain parity check: define IO_CFG_PARITY_EN.
module logical_tile_io_array_cfg #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  output logic              cfg_done
`ifdef IO_CFG_PARITY_EN
  ,
  output logic              cfg_err
`endif
);

`ifdef IO_CFG_PARITY_EN
  localparam int CHAIN_L = 2 * NUM_IO + 1;
`else
  localparam int CHAIN_L = 2 * NUM_IO;
`endif
  localparam int CNT_W = $clog2(CHAIN_L + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_L);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CHAIN_L-1:0] sr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_IO-1:0]  act;
  logic               blk;

`ifdef IO_CFG_PARITY_EN
  logic err_q;
  assign cfg_err = err_q;
  assign blk     = err_q;
`else
  assign blk     = 1'b0;
`endif

  assign ccff_tail = sr[CHAIN_L-1];

  // Chain shift, load counter and completion/parity flags.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sr       <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
`ifdef IO_CFG_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else if (ccff_en) begin
      sr <= {sr[CHAIN_L-2:0], ccff_head};
      if (cfg_done) begin
        cnt      <= CNT_ONE;
        cfg_done <= 1'b0;
`ifdef IO_CFG_PARITY_EN
        err_q    <= 1'b0;
`endif
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end else if (cnt == CNT_MAX) begin
      cfg_done <= 1'b1;
`ifdef IO_CFG_PARITY_EN
      err_q    <= ^sr;
`endif
    end
  end

  // Per-channel gating of pad direction and data paths.
  always_comb begin
    act                              = '0;
    gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = '0;
    gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = '0;
    io_inpad                         = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      act[i] = cfg_done & IO_ISOL_N & sr[2*i+1] & ~blk;
      gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] = act[i] & sr[2*i];
      gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i] =
        gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] & io_outpad[i];
      io_inpad[i] = act[i] & ~sr[2*i]
                  & gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i];
    end
  end

endmodule

// File: tb/tb_logical_tile_io_array_cfg.sv
// Bench for logical_tile_io_array_cfg: directed scenarios plus
// randomized traffic against a bit-history reference model.
module tb_logical_tile_io_array_cfg;

  localparam int N = 4;
`ifdef IO_CFG_PARITY_EN
  localparam int CL = 2 * N + 1;
`else
  localparam int CL = 2 * N;
`endif

  logic         prog_clk;
  logic         prog_reset;
  logic         iso_n;
  logic         ccff_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [N-1:0] pad_in;
  logic [N-1:0] pad_out;
  logic [N-1:0] pad_dir;
  logic [N-1:0] io_outpad;
  logic [N-1:0] io_inpad;
  logic         cfg_done;
  logic         cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  bit hist[$];
  int m_cnt;
  bit m_done;
  bit m_err;

  logic_tile_io_array_cfg_wrap_unused_guard g_unused();

  logical_tile_io_array_cfg #(.NUM_IO(N)) dut (
    .prog_clk                         (prog_clk),
    .prog_reset                       (prog_reset),
    .IO_ISOL_N                        (iso_n),
    .ccff_en                          (ccff_en),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .io_outpad                        (io_outpad),
    .io_inpad                         (io_inpad),
    .cfg_done                         (cfg_done)
`ifdef IO_CFG_PARITY_EN
    ,
    .cfg_err                          (cfg_err)
`endif
  );

`ifndef IO_CFG_PARITY_EN
  assign cfg_err = 1'b0;
`endif

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register image bit k = k-th most recent bit shifted in.
  function automatic bit srb(int k);
    int idx;
    idx = hist.size() - 1 - k;
    if (idx < 0) return 1'b0;
    return hist[idx];
  endfunction

  function automatic bit hist_par();
    bit p;
    p = 1'b0;
    foreach (hist[j]) p ^= hist[j];
    return p;
  endfunction

  task automatic model_edge(input bit rst, input bit en,
                            input bit head);
    if (rst) begin
      hist.delete();
      m_cnt  = 0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else if (en) begin
      hist.push_back(head);
      if (hist.size() > CL) void'(hist.pop_front());
      if (m_done) begin
        m_cnt  = 1;
        m_done = 1'b0;
        m_err  = 1'b0;
      end else if (m_cnt < CL) begin
        m_cnt++;
      end
    end else if (m_cnt == CL) begin
      m_done = 1'b1;
`ifdef IO_CFG_PARITY_EN
      m_err = hist_par();
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] e_dir, e_out, e_in;
    bit a;
    e_dir = '0;
    e_out = '0;
    e_in  = '0;
    for (int i = 0; i < N; i++) begin
      a = m_done && iso_n && srb(2*i+1) && !m_err;
      if (a && srb(2*i)) begin
        e_dir[i] = 1'b1;
        e_out[i] = io_outpad[i];
      end
      if (a && !srb(2*i)) e_in[i] = pad_in[i];
    end
    chk({tag, ".tail"}, 32'(ccff_tail), 32'(srb(CL-1)));
    chk({tag, ".dir"},  32'(pad_dir),   32'(e_dir));
    chk({tag, ".out"},  32'(pad_out),   32'(e_out));
    chk({tag, ".in"},   32'(io_inpad),  32'(e_in));
    chk({tag, ".done"}, 32'(cfg_done),  32'(m_done));
    chk({tag, ".err"},  32'(cfg_err),   32'(m_err));
  endtask

  task automatic tick(input bit rst, input bit en, input bit head);
    prog_reset = rst;
    ccff_en    = en;
    ccff_head  = head;
    @(posedge prog_clk);
    model_edge(rst, en, head);
    @(negedge prog_clk);
    check_outputs("tick");
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int k = n - 1; k >= 0; k--) tick(1'b0, 1'b1, t[k]);
  endtask

  initial begin
    prog_reset = 1'b1;
    ccff_en    = 1'b0;
    ccff_head  = 1'b0;
    iso_n      = 1'b1;
    io_outpad  = 4'hF;
    pad_in     = 4'hF;
    m_cnt      = 0;
    m_done     = 1'b0;
    m_err      = 1'b0;
    @(negedge prog_clk);

    // reset state
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst.dir", 32'(pad_dir), 32'h0);
    chk("rst.out", 32'(pad_out), 32'h0);
    chk("rst.in", 32'(io_inpad), 32'h0);
    chk("rst.done", 32'(cfg_done), 32'h0);
    chk("rst.tail", 32'(ccff_tail), 32'h0);

    // full load of 8'h4B
    shift_bits(16'h004B, 8);
    chk("load.done_early", 32'(cfg_done), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    chk("load.done", 32'(cfg_done), 32'h1);
    io_outpad = 4'b0001;
    pad_in    = 4'b1110;
    #1;
    chk("load.dir", 32'(pad_dir), 32'h1);
    chk("load.out", 32'(pad_out), 32'h1);
    chk("load.in", 32'(io_inpad), 32'h2);
    check_outputs("load");

    // isolation
    iso_n = 1'b0;
    #1;
    chk("iso.dir", 32'(pad_dir), 32'h0);
    chk("iso.out", 32'(pad_out), 32'h0);
    chk("iso.in", 32'(io_inpad), 32'h0);
    chk("iso.done", 32'(cfg_done), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    iso_n = 1'b1;
    #1;
    chk("iso_rel.dir", 32'(pad_dir), 32'h1);
    chk("iso_rel.out", 32'(pad_out), 32'h1);
    chk("iso_rel.in", 32'(io_inpad), 32'h2);

    // reprogramming restarts the count
    tick(1'b0, 1'b1, 1'b0);
    chk("reprog.done", 32'(cfg_done), 32'h0);
    chk("reprog.tail", 32'(ccff_tail), 32'h1);
    shift_bits(16'h004B, 7);
    chk("reprog.done_early", 32'(cfg_done), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    chk("reprog.done2", 32'(cfg_done), 32'h1);
    #1;
    chk("reprog.dir", 32'(pad_dir), 32'h1);

    // partial load, then reset and full load
    tick(1'b1, 1'b0, 1'b0);
    shift_bits(16'h0015, 5);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("partial.done", 32'(cfg_done), 32'h0);
    end
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 7; k >= 0; k--) begin
      logic [7:0] img;
      img = 8'h4B;
      tick(1'b0, 1'b1, img[k]);
      chk("full.done_early", 32'(cfg_done), 32'h0);
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("full.done", 32'(cfg_done), 32'h1);

`ifdef IO_CFG_PARITY_EN
    // odd parity image, then corrected reload
    tick(1'b1, 1'b0, 1'b0);
    shift_bits(16'h014B, 9);
    tick(1'b0, 1'b0, 1'b0);
    chk("par_bad.done", 32'(cfg_done), 32'h1);
    chk("par_bad.err", 32'(cfg_err), 32'h1);
    chk("par_bad.dir", 32'(pad_dir), 32'h0);
    chk("par_bad.in", 32'(io_inpad), 32'h0);
    shift_bits(16'h004B, 9);
    tick(1'b0, 1'b0, 1'b0);
    chk("par_ok.err", 32'(cfg_err), 32'h0);
    chk("par_ok.dir", 32'(pad_dir), 32'h1);
    chk("par_ok.in", 32'(io_inpad), 32'h2);
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit r, e, h;
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 2) != 0);
      h = 1'($urandom);
      tick(r, e, h);
      iso_n     = ($urandom_range(0, 7) != 0);
      io_outpad = N'($urandom);
      pad_in    = N'($urandom);
      #1;
      check_outputs("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

module logic_tile_io_array_cfg_wrap_unused_guard;
endmodule
